// File: rtl/shift_sequencer_32bit.sv
// rtl/shift_sequencer_32bit.sv - multi-cycle 0..31 logical shift built from one single-position shifter
// Feeds the external shifter from registers and folds its output back one position per clock.
module shift_sequencer_32bit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               dir,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   sh_d,
  output logic               sh_c,
  input  logic [WIDTH-1:0]   sh_s,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // start beats a coincident abort: abort has no meaning outside SHIFT
        if (start) begin
          work_d  = data_in;
          dir_d   = dir;
          count_d = shamt;
          busy_d  = 1'b1;
          if (shamt == '0) begin
            state_d  = S_DONE;
            result_d = data_in;
            done_d   = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end else begin
          work_d  = sh_s;
          count_d = count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_d  = S_DONE;
            result_d = sh_s;
            done_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sh_d   = work_q;
  assign sh_c   = dir_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_sequencer_32bit.sv
// tb/tb_shift_sequencer_32bit.sv - randomized bench for shift_sequencer_32bit against a transaction-level model
module tb_shift_sequencer_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        dir;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] sh_d;
  logic        sh_c;
  logic [31:0] sh_s;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_result;

  always #5 clk = ~clk;

  // Stand-in for the single-position shifter the sequencer drives
  assign sh_s = sh_c ? {sh_d[30:0], 1'b0} : {1'b0, sh_d[31:1]};

  shift_sequencer_32bit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
    .data_in(data_in), .shamt(shamt), .sh_d(sh_d), .sh_c(sh_c), .sh_s(sh_s),
    .result(result), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic left, input int n);
    return left ? (d << n) : (d >> n);
  endfunction

  // Called at a negedge with the DUT idle. a: cycle index whose edge samples abort
  // (-1 none); r: same for a spurious start; ab0: abort raised together with start.
  task automatic run_op(input logic [31:0] d, input logic l, input int sh,
                        input int a, input int r, input logic ab0);
    logic [31:0] exp;
    int          last;
    bit          aborted;
    aborted = (a >= 1) && (a <= sh);
    exp     = ref_shift(d, l, sh);
    last    = aborted ? a : sh + 1;
    start   = 1'b1;
    data_in = d;
    dir     = l;
    shamt   = sh[4:0];
    abort   = ab0;
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start   = (k + 1 == r) && (k < last);
      abort   = (k + 1 == a) && (k < last);
      data_in = $urandom;
      dir     = 1'($urandom);
      shamt   = 5'($urandom);
      if (aborted) begin
        check_eq("busy", 32'(busy), 32'(k < a));
        check_eq("done", 32'(done), 32'd0);
        check_eq("result_hold", result, prev_result);
      end else begin
        check_eq("busy", 32'(busy), 32'(k <= sh));
        check_eq("done", 32'(done), 32'(k == sh));
        check_eq("result", result, (k >= sh) ? exp : prev_result);
      end
      check_eq("sh_c", 32'(sh_c), 32'(l));
      if (k <= sh && (!aborted || k < a))
        check_eq("sh_d", sh_d, ref_shift(d, l, k));
    end
    if (!aborted) prev_result = exp;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int sh, a, r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0; data_in = '0; shamt = '0;
    prev_result = '0;
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_sh_d", sh_d, 32'd0);
    check_eq("rst_sh_c", 32'(sh_c), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h0000_0001, 1'b1, 4, -1, -1, 1'b0);
    check_eq("tp_left", result, 32'h0000_0010);
    run_op(32'h8000_0000, 1'b0, 31, -1, -1, 1'b0);
    check_eq("tp_right31", result, 32'h0000_0001);
    run_op(32'hDEAD_BEEF, 1'b1, 0, -1, -1, 1'b0);
    check_eq("tp_zero", result, 32'hDEAD_BEEF);
    run_op(32'h0000_00FF, 1'b1, 5, -1, 2, 1'b0);
    check_eq("tp_busy_start", result, 32'h0000_1FE0);
    run_op(32'h0000_0001, 1'b1, 4, -1, -1, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b1, 8, 3, -1, 1'b0);
    check_eq("tp_abort", result, 32'h0000_0010);
    run_op(32'h0000_0F00, 1'b0, 4, -1, -1, 1'b1);
    check_eq("tp_start_wins", result, 32'h0000_00F0);
    run_op(32'h1234_5678, 1'b0, 3, 4, 4, 1'b0);

    for (int i = 0; i < 30; i++) begin
      sh = $urandom_range(0, 31);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, sh + 1) : -1;
      r  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, sh + 1) : -1;
      run_op($urandom, 1'($urandom), sh, a, r, 1'($urandom_range(0, 4) == 0));
    end

    start = 1'b1; data_in = 32'hA5A5_0001; dir = 1'b1; shamt = 5'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", result, 32'd0);
    check_eq("arst_sh_d", sh_d, 32'd0);
    check_eq("arst_sh_c", 32'(sh_c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_result = '0;
    @(negedge clk);
    run_op(32'h0000_0001, 1'b1, 1, -1, -1, 1'b0);
    check_eq("arst_after", result, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
